cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the 8-bit CPU core. It steps each 16-bit instruction through fetch, decode, execute, memory and writeback. It drives the PC, instruction register, register file, ALU and data-memory strobes from the decoded 4-bit opcode. Data-memory access uses a ready handshake with a timeout. The block replaces the open-loop control FSM and is instantiated alongside PC, Decoder and Register_file in CPU_Core.

---
 rtl/cpu_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 8-bit core.
// Data-memory accesses wait on mem_ready with a bounded timeout that halts the core on expiry.
module cpu_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Opcode,
    input  logic       zero_flag,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       jump_en,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [3:0] ALUOp,
    output logic       ALUsrc,
    output logic       halted,
    output logic       illegal_op,
    output logic       bus_error,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_LOAD  = 4'b0110;
    localparam logic [3:0] OP_STORE = 4'b0111;
    localparam logic [3:0] OP_JMP   = 4'b1000;
    localparam logic [3:0] OP_BEQZ  = 4'b1001;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // Wait counter value seen in the MEM cycle that exhausts the timeout budget.
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic       run_q;
    logic [3:0] op_q;
    logic [7:0] wait_q;
    logic       illegal_q;
    logic       bus_err_q;

    logic       op_alu_reg;
    logic       op_illegal;
    logic       op_load;
    logic       timeout_hit;
    logic [3:0] exec_alu_op;
    logic       exec_alu_src;

    assign op_alu_reg   = (op_q >= OP_ADD) && (op_q <= OP_OR);
    assign op_illegal   = (op_q >= 4'b1010) && (op_q <= 4'b1110);
    assign op_load      = (op_q == OP_LOAD);
    assign timeout_hit  = (wait_q == WAIT_LIMIT);
    assign exec_alu_op  = op_alu_reg ? op_q : OP_ADD;
    assign exec_alu_src = !op_alu_reg;

    assign illegal_op = illegal_q;
    assign bus_error  = bus_err_q;
    assign state      = state_q;

    // run_q is the first release stage; the state register itself is the second.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q   <= 1'b0;
            state_q <= ST_RESET;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            if (state_q == ST_DECODE) begin
                op_q <= Opcode;
            end
            wait_q <= (state_q == ST_MEM && !mem_ready) ? wait_q + 8'd1 : '0;
            if (state_q == ST_EXEC && op_illegal) begin
                illegal_q <= 1'b1;
            end
            if (state_q == ST_MEM && !mem_ready && timeout_hit) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        jump_en  = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUOp    = '0;
        ALUsrc   = 1'b0;
        halted   = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (run_q) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                IRWrite = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        ALUOp   = exec_alu_op;
                        ALUsrc  = exec_alu_src;
                        state_d = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        ALUOp   = exec_alu_op;
                        ALUsrc  = exec_alu_src;
                        state_d = ST_MEM;
                    end
                    OP_JMP: begin
                        PCWrite = 1'b1;
                        jump_en = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OP_BEQZ: begin
                        PCWrite = 1'b1;
                        jump_en = zero_flag;
                        state_d = ST_FETCH;
                    end
                    OP_HALT: begin
                        state_d = ST_HALT;
                    end
                    default: begin
                        // NOP and the undefined opcodes both just advance the PC.
                        PCWrite = 1'b1;
                        state_d = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                MemRead  = op_load;
                MemWrite = !op_load;
                if (mem_ready) begin
                    if (op_load) begin
                        state_d = ST_WB;
                    end else begin
                        PCWrite = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_HALT;
                end
            end
            ST_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                ALUOp    = exec_alu_op;
                ALUsrc   = exec_alu_src;
                state_d  = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    assert property (@(posedge clk) disable iff (!rst)
        $onehot0({IRWrite, RegWrite, MemRead, MemWrite}));
    assert property (@(posedge clk) disable iff (!rst) jump_en |-> PCWrite);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomised scoreboard bench for cpu_sequencer: per-instruction cycle traces are built from
// the opcode rules and queued; a negedge monitor compares every cycle's outputs against them.
module tb_cpu_sequencer;

    localparam int unsigned MEM_T = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Opcode;
    logic       zero_flag;
    logic       mem_ready;
    logic       IRWrite;
    logic       PCWrite;
    logic       jump_en;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic [3:0] ALUOp;
    logic       ALUsrc;
    logic       halted;
    logic       illegal_op;
    logic       bus_error;
    logic [2:0] state;

    cpu_sequencer #(.MEM_TIMEOUT(MEM_T)) dut (
        .clk        (clk),
        .rst        (rst),
        .Opcode     (Opcode),
        .zero_flag  (zero_flag),
        .mem_ready  (mem_ready),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .jump_en    (jump_en),
        .RegWrite   (RegWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .ALUOp      (ALUOp),
        .ALUsrc     (ALUsrc),
        .halted     (halted),
        .illegal_op (illegal_op),
        .bus_error  (bus_error),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [16:0] vec;
        logic [3:0]  op;
        logic [3:0]  phase;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          ill_m;
    bit          berr_m;
    logic [3:0]  cur_op;
    logic [16:0] act_vec;

    assign act_vec = {IRWrite, PCWrite, jump_en, RegWrite, MemRead, MemWrite,
                      ALUOp, ALUsrc, halted, illegal_op, bus_error, state};

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [3:0] r4();
        return 4'($urandom);
    endfunction

    function automatic logic [16:0] mk(input logic ir, input logic pc, input logic j,
                                       input logic rw, input logic mr, input logic mw,
                                       input logic [3:0] aop, input logic asrc,
                                       input logic [2:0] st);
        return {ir, pc, j, rw, mr, mw, aop, asrc, st == 3'd6, ill_m, berr_m, st};
    endfunction

    task automatic cyc(input logic r, input logic [3:0] opc, input logic zf, input logic mr,
                       input logic [16:0] v, input logic [3:0] ph);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        Opcode    = opc;
        zero_flag = zf;
        mem_ready = mr;
        e.vec   = v;
        e.op    = cur_op;
        e.phase = ph;
        exp_q.push_back(e);
    endtask

    // Reset asserted just after an edge must clear everything before the next edge;
    // FETCH follows on the second edge after release.
    task automatic do_reset(input int unsigned n);
        ill_m  = 1'b0;
        berr_m = 1'b0;
        cur_op = 4'h0;
        for (int unsigned i = 0; i < n; i++) cyc(1'b0, r4(), rb(), rb(), '0, 4'd0);
        cyc(1'b1, r4(), rb(), rb(), '0, 4'd0);
        cyc(1'b1, r4(), rb(), rb(), '0, 4'd0);
    endtask

    task automatic run_halt(input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            cyc(1'b1, r4(), rb(), rb(), mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 3'd6), 4'd6);
    endtask

    // w = MEM cycles including the ready cycle; w = 0 means mem_ready never comes.
    // abort_k > 0 stops after that many unanswered MEM cycles (caller then resets).
    task automatic run_instr(input logic [3:0] opc, input logic zf, input int unsigned w,
                             input int unsigned abort_k);
        logic [3:0] aop;
        logic       asrc;
        logic       pcx;
        logic       jx;
        logic       ld;
        logic       stx;
        logic       last;
        bit         to_wb;
        bit         to_mem;
        aop    = 4'h0;
        asrc   = 1'b0;
        pcx    = 1'b0;
        jx     = 1'b0;
        to_wb  = 1'b0;
        to_mem = 1'b0;
        ld     = (opc == 4'd6);
        stx    = (opc == 4'd7);
        cur_op = opc;
        cyc(1'b1, r4(), rb(), rb(), mk(1, 0, 0, 0, 0, 0, 4'h0, 0, 3'd1), 4'd1);
        cyc(1'b1, opc, rb(), rb(), mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 3'd2), 4'd2);
        if (opc >= 4'd1 && opc <= 4'd4) begin
            aop = opc; to_wb = 1'b1;
        end else if (opc == 4'd5) begin
            aop = 4'd1; asrc = 1'b1; to_wb = 1'b1;
        end else if (ld || stx) begin
            aop = 4'd1; asrc = 1'b1; to_mem = 1'b1;
        end else if (opc == 4'd8) begin
            pcx = 1'b1; jx = 1'b1;
        end else if (opc == 4'd9) begin
            pcx = 1'b1; jx = zf;
        end else if (opc != 4'd15) begin
            pcx = 1'b1;
        end
        cyc(1'b1, r4(), zf, rb(), mk(0, pcx, jx, 0, 0, 0, aop, asrc, 3'd3), 4'd3);
        if (opc >= 4'd10 && opc <= 4'd14) ill_m = 1'b1;
        if (to_mem) begin
            if (abort_k > 0) begin
                for (int unsigned i = 0; i < abort_k; i++)
                    cyc(1'b1, r4(), rb(), 1'b0, mk(0, 0, 0, 0, ld, stx, 4'h0, 0, 3'd4), 4'd4);
                return;
            end
            if (w == 0) begin
                for (int unsigned i = 0; i < MEM_T; i++)
                    cyc(1'b1, r4(), rb(), 1'b0, mk(0, 0, 0, 0, ld, stx, 4'h0, 0, 3'd4), 4'd4);
                berr_m = 1'b1;
                return;
            end
            for (int unsigned i = 0; i < w; i++) begin
                last = (i == w - 1);
                cyc(1'b1, r4(), rb(), last, mk(0, stx & last, 0, 0, ld, stx, 4'h0, 0, 3'd4), 4'd4);
            end
            to_wb = ld;
        end
        if (to_wb)
            cyc(1'b1, r4(), rb(), rb(), mk(0, 1, 0, 1, 0, 0, aop, asrc, 3'd5), 4'd5);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act_vec !== e.vec) begin
                n_fail++;
                $display("FAIL out_vec op=%h phase=%0d t=%0t act=%h req=%h",
                         e.op, e.phase, $time, act_vec, e.vec);
            end
        end
    end

    initial begin
        rst       = 1'b0;
        Opcode    = 4'h0;
        zero_flag = 1'b0;
        mem_ready = 1'b0;
        ill_m     = 1'b0;
        berr_m    = 1'b0;
        cur_op    = 4'h0;

        do_reset(3);
        run_instr(4'd1, 1'b0, 0, 0);
        run_instr(4'd5, 1'b0, 0, 0);
        run_instr(4'd6, 1'b0, 4, 0);
        run_instr(4'd9, 1'b1, 0, 0);
        run_instr(4'd9, 1'b0, 0, 0);
        run_instr(4'd12, 1'b0, 0, 0);
        run_instr(4'd0, 1'b0, 0, 0);
        run_instr(4'd8, 1'b0, 0, 0);
        run_instr(4'd7, 1'b0, 1, 0);
        run_instr(4'd6, 1'b0, MEM_T, 0);
        run_instr(4'd7, 1'b0, MEM_T, 0);
        for (int i = 0; i < 40; i++)
            run_instr(4'($urandom_range(0, 14)), rb(), $urandom_range(1, MEM_T), 0);

        run_instr(4'd7, 1'b0, 0, 0);
        run_halt(20);

        do_reset(2);
        run_instr(4'd15, 1'b0, 0, 0);
        run_halt(22);

        do_reset(1);
        run_instr(4'd11, 1'b0, 0, 0);
        run_instr(4'd6, 1'b0, 0, 3);
        do_reset(1);
        run_instr(4'd2, 1'b0, 0, 0);
        run_instr(4'd6, 1'b1, 2, 0);
        for (int i = 0; i < 10; i++)
            run_instr(4'($urandom_range(0, 14)), rb(), $urandom_range(1, MEM_T), 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain act=%0d req=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
